// File: rtl/scroll_blitter.sv
// scroll_blitter: copies one 2^OBJ_W_BITS x 2^OBJ_H_BITS object from a
// 1-cycle-latency ROM to the VGA adapter pixel port. The object is placed at
// (x_origin_i, y_origin_i + y_off_o) and a vertical scroll offset is stepped
// by a single-cycle enable.
// Ports:
//   Clock, Resetn       system clock, synchronous active-low reset
//   start_i             begin one object copy (accepted only in IDLE)
//   step_en_i, dir_i    scroll tick; dir 0 = y_off up, 1 = y_off down
//   x_origin_i/y_origin_i  object top-left, latched when start is accepted
//   mem_addr_o/mem_data_i  ROM address {row,col} and data one cycle later
//   vga_x_o/vga_y_o/vga_colour_o/plot_o  pixel write port
//   busy_o, done_o      copy in progress / 1-cycle end-of-copy pulse
//   y_off_o             current scroll offset, 0..SCREEN_H-1
module scroll_blitter #(
    parameter int OBJ_W_BITS  = 3,
    parameter int OBJ_H_BITS  = 3,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int SCREEN_H    = 120,
    parameter int COLOUR_BITS = 3
) (
    input  logic                             Clock,
    input  logic                             Resetn,
    input  logic                             start_i,
    input  logic                             step_en_i,
    input  logic                             dir_i,
    input  logic [X_BITS-1:0]                x_origin_i,
    input  logic [Y_BITS-1:0]                y_origin_i,
    output logic [OBJ_H_BITS+OBJ_W_BITS-1:0] mem_addr_o,
    input  logic [COLOUR_BITS-1:0]           mem_data_i,
    output logic [X_BITS-1:0]                vga_x_o,
    output logic [Y_BITS-1:0]                vga_y_o,
    output logic [COLOUR_BITS-1:0]           vga_colour_o,
    output logic                             plot_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [Y_BITS-1:0]                y_off_o
);
    localparam int A = OBJ_H_BITS + OBJ_W_BITS;
    localparam logic [Y_BITS+1:0] H_W = (Y_BITS+2)'(SCREEN_H);
    localparam logic [Y_BITS-1:0] H_MAX = Y_BITS'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;
    state_t state_q, state_d;

    logic [A-1:0]      addr_q;
    logic [X_BITS-1:0] x_q, vga_x_q, vga_x_d;
    logic [Y_BITS-1:0] y_q, snap_q, vga_y_q, vga_y_d, y_off_q, y_off_d, y_step;
    logic              plot_q, pend_q, pend_d, apply_step, accept;
    logic [Y_BITS+1:0] y_sum, y_sub;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start_i ? DRAW : IDLE;
            DRAW:    state_d = &addr_q ? FLUSH : DRAW;
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // A tick seen while busy is remembered and applied on the DONE -> IDLE
    // edge, so the offset never changes in the middle of a copy.
    always_comb begin
        accept     = (state_q == IDLE) && start_i;
        apply_step = ((state_q == IDLE) && step_en_i) || ((state_q == DONE) && (pend_q || step_en_i));
        pend_d     = (state_q == IDLE || state_q == DONE) ? 1'b0 : (pend_q | step_en_i);
        y_step     = dir_i ? ((y_off_q == '0) ? H_MAX : y_off_q - 1'b1)
                           : ((y_off_q == H_MAX) ? '0 : y_off_q + 1'b1);
        y_off_d    = apply_step ? y_step : y_off_q;
        vga_x_d    = x_q + X_BITS'(addr_q[OBJ_W_BITS-1:0]);
        // Operands are each below 2*SCREEN_H-ish, so two subtracts bring the
        // sum back into 0..SCREEN_H-1.
        y_sum      = {2'b00, y_q} + {2'b00, snap_q} + (Y_BITS+2)'(addr_q[A-1:OBJ_W_BITS]);
        y_sub      = (y_sum >= H_W) ? y_sum - H_W : y_sum;
        vga_y_d    = Y_BITS'((y_sub >= H_W) ? y_sub - H_W : y_sub);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            snap_q  <= '0;
            vga_x_q <= '0;
            vga_y_q <= '0;
            plot_q  <= 1'b0;
            pend_q  <= 1'b0;
            y_off_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            y_off_q <= y_off_d;
            plot_q  <= (state_q == DRAW);
            if (accept) begin
                x_q    <= x_origin_i;
                y_q    <= y_origin_i;
                snap_q <= y_off_q;
                addr_q <= '0;
            end else if (state_q == DRAW && !(&addr_q)) begin
                addr_q <= addr_q + 1'b1;
            end
            // Coordinates track the address just issued so they line up
            // with the ROM data returned on the following cycle.
            if (state_q == DRAW) begin
                vga_x_q <= vga_x_d;
                vga_y_q <= vga_y_d;
            end
        end
    end

    assign mem_addr_o   = addr_q;
    assign vga_x_o      = vga_x_q;
    assign vga_y_o      = vga_y_q;
    assign vga_colour_o = mem_data_i;
    assign plot_o       = plot_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign y_off_o      = y_off_q;
endmodule

// File: tb/tb_scroll_blitter.sv
// tb_scroll_blitter: randomized self-checking bench for scroll_blitter
module tb_scroll_blitter;
    localparam int N = 64;
    localparam int H = 120;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       start_i = 1'b0;
    logic       step_en_i = 1'b0;
    logic       dir_i = 1'b0;
    logic [7:0] x_origin_i = '0;
    logic [6:0] y_origin_i = '0;
    logic [5:0] mem_addr_o;
    logic [2:0] mem_data_i = '0;
    logic [7:0] vga_x_o;
    logic [6:0] vga_y_o;
    logic [2:0] vga_colour_o;
    logic       plot_o, busy_o, done_o;
    logic [6:0] y_off_o;

    logic [2:0] rom [N];
    int checks = 0;
    int errors = 0;
    int m_yoff = 0;

    scroll_blitter dut (
        .Clock(Clock), .Resetn(Resetn), .start_i(start_i), .step_en_i(step_en_i),
        .dir_i(dir_i), .x_origin_i(x_origin_i), .y_origin_i(y_origin_i),
        .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i), .vga_x_o(vga_x_o),
        .vga_y_o(vga_y_o), .vga_colour_o(vga_colour_o), .plot_o(plot_o),
        .busy_o(busy_o), .done_o(done_o), .y_off_o(y_off_o)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) mem_data_i <= rom[mem_addr_o];

    initial begin
        #1ms;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clock);
    endtask

    function automatic int nxt(input int v, input bit d);
        return d ? (v == 0 ? H - 1 : v - 1) : (v == H - 1 ? 0 : v + 1);
    endfunction

    task automatic step(input bit d, input int n);
        for (int i = 0; i < n; i++) begin
            step_en_i = 1'b1;
            dir_i = d;
            cyc();
            m_yoff = nxt(m_yoff, d);
        end
        step_en_i = 1'b0;
        chk("y_off_step", y_off_o, m_yoff);
    endtask

    task automatic fill_rom();
        for (int i = 0; i < N; i++) rom[i] = 3'($urandom);
    endtask

    // One object copy; optional ticks while busy, a tick coincident with
    // start, and a reset asserted at cycle 'abort' (0 = none).
    task automatic copy(input int x, input int y, input bit d, input bit ticks,
                        input bit costep, input int abort);
        int snap, p;
        snap = m_yoff;
        fill_rom();
        x_origin_i = 8'(x);
        y_origin_i = 7'(y);
        dir_i = d;
        start_i = 1'b1;
        step_en_i = costep;
        cyc();
        start_i = 1'b0;
        step_en_i = 1'b0;
        if (costep) m_yoff = nxt(m_yoff, d);
        for (int k = 1; k <= N + 2; k++) begin
            if (k == abort) begin
                Resetn = 1'b0;
                cyc();
                Resetn = 1'b1;
                m_yoff = 0;
                chk("rst_busy", busy_o, 0);
                chk("rst_done", done_o, 0);
                chk("rst_plot", plot_o, 0);
                chk("rst_addr", mem_addr_o, 0);
                chk("rst_x", vga_x_o, 0);
                chk("rst_y", vga_y_o, 0);
                chk("rst_yoff", y_off_o, 0);
                for (int j = 0; j < 40; j++) begin
                    cyc();
                    chk("abort_nodone", {busy_o, done_o, plot_o}, 0);
                end
                return;
            end
            chk("busy", busy_o, 1);
            chk("done", done_o, k == N + 2);
            chk("plot", plot_o, k >= 2 && k <= N + 1);
            chk("y_off_busy", y_off_o, m_yoff);
            if (k <= N) chk("addr", mem_addr_o, k - 1);
            if (k >= 2 && k <= N + 1) begin
                p = k - 2;
                chk("vga_x", vga_x_o, (x + p % 8) % 256);
                chk("vga_y", vga_y_o, (y + snap + p / 8) % H);
                chk("colour", vga_colour_o, rom[p]);
            end
            step_en_i = ticks && (k == 5 || k == 9 || k == 13);
            cyc();
        end
        step_en_i = 1'b0;
        if (ticks) m_yoff = nxt(m_yoff, d);
        chk("busy_end", busy_o, 0);
        chk("done_end", done_o, 0);
        chk("plot_end", plot_o, 0);
        chk("y_off_end", y_off_o, m_yoff);
        cyc();
    endtask

    initial begin
        cyc();
        cyc();
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_plot", plot_o, 0);
        chk("reset_addr", mem_addr_o, 0);
        chk("reset_x", vga_x_o, 0);
        chk("reset_y", vga_y_o, 0);
        chk("reset_yoff", y_off_o, 0);
        Resetn = 1'b1;
        cyc();
        copy(10, 20, 1'b0, 1'b0, 1'b0, 0);
        copy(10, 115, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 120);
        chk("wrap_up", y_off_o, 0);
        step(1'b1, 1);
        chk("wrap_down", y_off_o, 119);
        step(1'b0, 1);
        copy(30, 40, 1'b0, 1'b1, 1'b0, 0);
        copy(50, 60, 1'b1, 1'b1, 1'b0, 0);
        copy(70, 5, 1'b1, 1'b0, 1'b1, 0);
        step(1'b0, 3);
        copy(12, 34, 1'b0, 1'b0, 1'b0, 30);
        copy(12, 34, 1'b0, 1'b0, 1'b0, 0);
        for (int r = 0; r < 8; r++) begin
            step(1'($urandom), int'($urandom_range(0, 150)));
            copy(int'($urandom_range(0, 255)), int'($urandom_range(0, H - 1)),
                 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
